// File: rtl/topk_result_out.sv
// Top-5 result streamer: latches the final sorter list of a job and
// delivers its non-empty entries as ranked beats over a valid/ready port.
module topk_result_out #(
    parameter int                    Data_Width  = 8,
    parameter int                    Index_Width = 16,
    parameter logic [Data_Width-1:0] MIN         = 8'h80
) (
    input  logic                                sys_clk,
    input  logic                                sys_rst_n,
    input  logic                                sorter_clr,
    input  logic [Index_Width+Data_Width-1:0]   sorter_out0,
    input  logic [Index_Width+Data_Width-1:0]   sorter_out1,
    input  logic [Index_Width+Data_Width-1:0]   sorter_out2,
    input  logic [Index_Width+Data_Width-1:0]   sorter_out3,
    input  logic [Index_Width+Data_Width-1:0]   sorter_out4,
    input  logic                                sorter_valid,
    input  logic                                last_sort_o,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [Index_Width-1:0]              out_index,
    output logic [Data_Width-1:0]               out_score,
    output logic [2:0]                          out_rank,
    output logic                                out_last,
    output logic [2:0]                          result_cnt,
    output logic                                done,
    output logic                                busy,
    output logic                                ovf_err
);

    localparam int EW = Index_Width + Data_Width;
    localparam logic [EW-1:0] EMPTY = {{Index_Width{1'b0}}, MIN};

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [EW-1:0] sin [5];
    logic [EW-1:0] ent [5];
    logic [EW-1:0] cur;
    logic [2:0]    cnt_nxt;
    logic [2:0]    rank;
    logic          run;
    logic          cap;
    logic          fire;

    assign sin[0] = sorter_out0;
    assign sin[1] = sorter_out1;
    assign sin[2] = sorter_out2;
    assign sin[3] = sorter_out3;
    assign sin[4] = sorter_out4;

    assign cap  = sorter_valid & last_sort_o;
    assign fire = out_valid & out_ready;

    // Leading non-empty run length; counting stops at the first empty slot.
    always_comb begin
        cnt_nxt = '0;
        run     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (run && sin[i] != EMPTY) cnt_nxt = cnt_nxt + 3'd1;
            else                        run     = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sorter_clr) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (cap) state_nxt = (cnt_nxt != 3'd0) ? SEND : DONE;
                SEND: if (fire && out_last) state_nxt = DONE;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 5; i++) ent[i] <= EMPTY;
            result_cnt <= '0;
            rank       <= '0;
            ovf_err    <= 1'b0;
        end else if (sorter_clr) begin
            for (int i = 0; i < 5; i++) ent[i] <= EMPTY;
            result_cnt <= '0;
            rank       <= '0;
            ovf_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cap) begin
                        for (int i = 0; i < 5; i++) ent[i] <= sin[i];
                        result_cnt <= cnt_nxt;
                        rank       <= '0;
                    end
                end
                SEND: begin
                    if (cap) ovf_err <= 1'b1;
                    if (fire && !out_last) rank <= rank + 3'd1;
                end
                DONE: begin
                    if (cap) ovf_err <= 1'b1;
                    rank <= '0;
                end
                default: rank <= '0;
            endcase
        end
    end

    always_comb begin
        cur       = ent[rank];
        out_valid = (state == SEND);
        busy      = (state != IDLE);
        done      = (state == DONE);
        out_last  = out_valid && (rank == result_cnt - 3'd1);
        out_rank  = out_valid ? rank : '0;
        out_index = out_valid ? cur[EW-1:Data_Width] : '0;
        out_score = out_valid ? cur[Data_Width-1:0] : '0;
    end

endmodule

// File: tb/tb_topk_result_out.sv
// Directed bench for topk_result_out: capture, streaming, backpressure,
// overflow, clear and asynchronous reset behaviour.
module tb_topk_result_out;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        sorter_clr;
    logic [23:0] sorter_out0, sorter_out1, sorter_out2, sorter_out3, sorter_out4;
    logic        sorter_valid;
    logic        last_sort_o;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_index;
    logic [7:0]  out_score;
    logic [2:0]  out_rank;
    logic        out_last;
    logic [2:0]  result_cnt;
    logic        done;
    logic        busy;
    logic        ovf_err;

    int vectors;
    int miscompares;

    localparam logic [23:0] E  = 24'h000080;
    localparam logic [23:0] F0 = {16'h0012, 8'h7F};
    localparam logic [23:0] F1 = {16'h0034, 8'h50};
    localparam logic [23:0] F2 = {16'h0001, 8'h10};
    localparam logic [23:0] F3 = {16'h0100, 8'hF0};
    localparam logic [23:0] F4 = {16'h0200, 8'h81};
    localparam logic [23:0] P0 = {16'h0005, 8'h20};
    localparam logic [23:0] P1 = {16'h0006, 8'h11};

    topk_result_out dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .sorter_clr  (sorter_clr),
        .sorter_out0 (sorter_out0),
        .sorter_out1 (sorter_out1),
        .sorter_out2 (sorter_out2),
        .sorter_out3 (sorter_out3),
        .sorter_out4 (sorter_out4),
        .sorter_valid(sorter_valid),
        .last_sort_o (last_sort_o),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .out_score   (out_score),
        .out_rank    (out_rank),
        .out_last    (out_last),
        .result_cnt  (result_cnt),
        .done        (done),
        .busy        (busy),
        .ovf_err     (ovf_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic load(input logic [23:0] a, b, c, d, e);
        sorter_out0 = a;
        sorter_out1 = b;
        sorter_out2 = c;
        sorter_out3 = d;
        sorter_out4 = e;
    endtask

    task automatic capture(input logic [23:0] a, b, c, d, e);
        load(a, b, c, d, e);
        sorter_valid = 1'b1;
        last_sort_o  = 1'b1;
        step();
        sorter_valid = 1'b0;
        last_sort_o  = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [2:0] r,
                        input logic [23:0] e, input logic l);
        logic [15:0] ei;
        logic [7:0]  es;
        ei = e[23:8];
        es = e[7:0];
        chk({tag, "_vld"},   out_valid, 1'b1);
        chk({tag, "_rank"},  out_rank,  r);
        chk({tag, "_idx"},   out_index, ei);
        chk({tag, "_score"}, out_score, es);
        chk({tag, "_last"},  out_last,  l);
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, "_vld"},   out_valid, 1'b0);
        chk({tag, "_busy"},  busy,      1'b0);
        chk({tag, "_done"},  done,      1'b0);
        chk({tag, "_last"},  out_last,  1'b0);
        chk({tag, "_idx"},   out_index, 16'h0);
        chk({tag, "_score"}, out_score, 8'h0);
        chk({tag, "_rank"},  out_rank,  3'd0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        sys_rst_n    = 1'b0;
        sorter_clr   = 1'b0;
        sorter_valid = 1'b0;
        last_sort_o  = 1'b0;
        out_ready    = 1'b1;
        load(E, E, E, E, E);

        #3;
        idle_outs("rst");
        chk("rst_cnt", result_cnt, 3'd0);
        chk("rst_ovf", ovf_err, 1'b0);
        step();
        sys_rst_n = 1'b1;
        step();

        // Non-final sorter update is ignored.
        load(F0, F1, F2, F3, F4);
        sorter_valid = 1'b1;
        step();
        sorter_valid = 1'b0;
        chk("nofinal_busy", busy, 1'b0);
        chk("nofinal_cnt", result_cnt, 3'd0);

        // Full list, ready held high.
        capture(F0, F1, F2, F3, F4);
        chk("full_cnt", result_cnt, 3'd5);
        chk("full_busy", busy, 1'b1);
        beat("full_b0", 3'd0, F0, 1'b0);
        step();
        beat("full_b1", 3'd1, F1, 1'b0);
        step();
        beat("full_b2", 3'd2, F2, 1'b0);
        step();
        beat("full_b3", 3'd3, F3, 1'b0);
        step();
        beat("full_b4", 3'd4, F4, 1'b1);
        step();
        chk("full_done", done, 1'b1);
        chk("full_done_vld", out_valid, 1'b0);
        chk("full_done_busy", busy, 1'b1);
        step();
        idle_outs("full_end");
        chk("full_cnt_hold", result_cnt, 3'd5);

        // Partial list.
        capture(P0, P1, E, E, E);
        chk("part_cnt", result_cnt, 3'd2);
        beat("part_b0", 3'd0, P0, 1'b0);
        step();
        beat("part_b1", 3'd1, P1, 1'b1);
        step();
        chk("part_done", done, 1'b1);
        chk("part_done_vld", out_valid, 1'b0);
        step();
        idle_outs("part_end");

        // Empty list: straight to DONE, busy for one cycle.
        capture(E, E, E, E, E);
        chk("empty_cnt", result_cnt, 3'd0);
        chk("empty_done", done, 1'b1);
        chk("empty_busy", busy, 1'b1);
        chk("empty_vld", out_valid, 1'b0);
        step();
        idle_outs("empty_end");

        // Empty head stops the count; index 1 with score 0x80 is not empty.
        capture(E, P0, P1, E, E);
        chk("head_cnt", result_cnt, 3'd0);
        chk("head_done", done, 1'b1);
        step();
        capture({16'h0001, 8'h80}, E, P0, E, E);
        chk("full24_cnt", result_cnt, 3'd1);
        beat("full24_b0", 3'd0, {16'h0001, 8'h80}, 1'b1);
        step();
        chk("full24_done", done, 1'b1);
        step();

        // Backpressure: three stalled cycles at rank 2.
        capture(F0, F1, F2, F3, F4);
        beat("bp_b0", 3'd0, F0, 1'b0);
        step();
        beat("bp_b1", 3'd1, F1, 1'b0);
        step();
        out_ready = 1'b0;
        beat("bp_s0", 3'd2, F2, 1'b0);
        step();
        beat("bp_s1", 3'd2, F2, 1'b0);
        step();
        beat("bp_s2", 3'd2, F2, 1'b0);
        step();
        out_ready = 1'b1;
        beat("bp_b2", 3'd2, F2, 1'b0);
        step();
        beat("bp_b3", 3'd3, F3, 1'b0);
        step();
        beat("bp_b4", 3'd4, F4, 1'b1);
        step();
        chk("bp_done", done, 1'b1);
        step();
        chk("bp_idle", busy, 1'b0);

        // Overflow: a second final list during SEND is dropped and flagged.
        capture(P0, P1, E, E, E);
        beat("ovf_b0", 3'd0, P0, 1'b0);
        load(F0, F1, F2, F3, F4);
        sorter_valid = 1'b1;
        last_sort_o  = 1'b1;
        step();
        sorter_valid = 1'b0;
        last_sort_o  = 1'b0;
        chk("ovf_flag", ovf_err, 1'b1);
        chk("ovf_cnt", result_cnt, 3'd2);
        beat("ovf_b1", 3'd1, P1, 1'b1);
        step();
        chk("ovf_done", done, 1'b1);
        step();
        chk("ovf_sticky", ovf_err, 1'b1);
        chk("ovf_idle", busy, 1'b0);
        sorter_clr = 1'b1;
        step();
        sorter_clr = 1'b0;
        chk("clr_ovf", ovf_err, 1'b0);
        chk("clr_cnt", result_cnt, 3'd0);
        idle_outs("clr");

        // Clear wins over a simultaneous capture.
        load(F0, F1, F2, F3, F4);
        sorter_valid = 1'b1;
        last_sort_o  = 1'b1;
        sorter_clr   = 1'b1;
        step();
        sorter_valid = 1'b0;
        last_sort_o  = 1'b0;
        sorter_clr   = 1'b0;
        idle_outs("clrcap");
        chk("clrcap_cnt", result_cnt, 3'd0);
        step();
        chk("clrcap_busy2", busy, 1'b0);

        // Asynchronous reset at rank 1 aborts delivery.
        capture(F0, F1, F2, F3, F4);
        step();
        beat("rstmid_b1", 3'd1, F1, 1'b0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        idle_outs("rstmid");
        chk("rstmid_cnt", result_cnt, 3'd0);
        chk("rstmid_ovf", ovf_err, 1'b0);
        step();
        sys_rst_n = 1'b1;
        step();
        idle_outs("rstmid_after");
        capture(P1, E, E, E, E);
        chk("resume_cnt", result_cnt, 3'd1);
        beat("resume_b0", 3'd0, P1, 1'b1);
        step();
        chk("resume_done", done, 1'b1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
